// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit: fixed-latency mult/div with architectural HI/LO.
// Optional abort of an in-flight op via the flush port when MD_FLUSH_EN is defined.
//
// state | meaning
// IDLE  | no op in flight, busy=0, mthi/mtlo and new MD ops accepted
// RUN   | op in flight, busy=1, cnt counts down, commit pending HI/LO when cnt==1
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_A,
    input  logic [31:0] src_B,
`ifdef MD_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic          pend_wr_q, pend_wr_d;

    logic          flush_now;
    logic [63:0]   prod_s, prod_u;
    logic          div_signed, a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

`ifdef MD_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // Division is done on magnitudes so the 0x80000000 / -1 case wraps cleanly.
    always_comb begin
        prod_s     = {{32{src_A[31]}}, src_A} * {{32{src_B[31]}}, src_B};
        prod_u     = {32'd0, src_A} * {32'd0, src_B};
        div_signed = (md_op == OP_DIV);
        a_neg      = div_signed & src_A[31];
        b_neg      = div_signed & src_B[31];
        a_mag      = a_neg ? (~src_A + 32'd1) : src_A;
        b_mag      = b_neg ? (~src_B + 32'd1) : src_B;
        b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem        = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        if (flush_now) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            cnt_d     = '0;
            pend_hi_d = '0;
            pend_lo_d = '0;
            pend_wr_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (md_op)
                            OP_MTHI: hi_d = src_A;
                            OP_MTLO: lo_d = src_A;
                            OP_MULT, OP_MULTU: begin
                                pend_hi_d = (md_op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
                                pend_lo_d = (md_op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
                                pend_wr_d = 1'b1;
                                cnt_d     = CW'(MULT_CYCLES);
                                busy_d    = 1'b1;
                                state_d   = RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_hi_d = rem;
                                pend_lo_d = quot;
                                pend_wr_d = (src_B != 32'd0);
                                cnt_d     = CW'(DIV_CYCLES);
                                busy_d    = 1'b1;
                                state_d   = RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt_q == CW'(1)) begin
                        if (pend_wr_q) begin
                            hi_d = pend_hi_q;
                            lo_d = pend_lo_q;
                        end
                        pend_wr_d = 1'b0;
                        cnt_d     = '0;
                        busy_d    = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus queues expected commits, a monitor checks them
// when busy falls. Define MD_FLUSH_EN to also exercise the flush path.
module tb_md_unit;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'b000;
    logic [31:0] src_A = '0;
    logic [31:0] src_B = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
    } exp_t;

    exp_t sb[$];
    bit   abort_flag = 1'b0;
    bit   prev_busy = 1'b0;
    bit   hold_ok = 1'b1;
    int   run_cycles = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .md_op (md_op),
        .src_A (src_A),
        .src_B (src_B),
`ifdef MD_FLUSH_EN
        .flush (flush),
`endif
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: counts busy cycles, checks HI/LO hold during RUN, compares at commit.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_busy  = 1'b0;
            run_cycles = 0;
            hold_ok    = 1'b1;
        end else begin
            if (busy === 1'b1) begin
                run_cycles++;
                if (sb.size() > 0 && (HI !== sb[0].old_hi || LO !== sb[0].old_lo))
                    hold_ok = 1'b0;
            end else if (prev_busy) begin
                if (abort_flag) begin
                    abort_flag = 1'b0;
                end else if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: got HI=0x%08h LO=0x%08h expected no op in flight", HI, LO);
                end else begin
                    e = sb.pop_front();
                    chk("commit_HI", HI, e.hi);
                    chk("commit_LO", LO, e.lo);
                    chk("busy_cycles", 32'(run_cycles), 32'(e.cycles));
                    chk("hold_during_run", {31'd0, hold_ok}, 32'd1);
                end
                run_cycles = 0;
                hold_ok    = 1'b1;
            end
            prev_busy = (busy === 1'b1);
        end
    end

    task automatic expect_op(input logic [31:0] hi, input logic [31:0] lo, input int cyc);
        exp_t e;
        e.hi = hi; e.lo = lo; e.cycles = cyc; e.old_hi = HI; e.old_lo = LO;
        sb.push_back(e);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; md_op = op; src_A = a; src_B = b;
        @(posedge clk);
        #1;
        start = 1'b0; md_op = 3'b000;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending commits expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic [31:0] save_hi, save_lo;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_HI", HI, 32'd0);
        chk("reset_LO", LO, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(OP_MTHI, 32'h11, 32'h0);
        chk("mthi_HI", HI, 32'h11);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        do_op(OP_MTLO, 32'h22, 32'h0);
        chk("mtlo_LO", LO, 32'h22);
        do_op(3'b111, 32'h99, 32'h0);
        chk("noop_busy", {31'd0, busy}, 32'd0);
        chk("noop_HI", HI, 32'h11);

        expect_op(32'h11, 32'h22, 10);
        do_op(OP_DIVU, 32'd7, 32'd0);
        wait_idle();

        expect_op(32'hFFFFFFFF, 32'hFFFFFFFE, 5);
        do_op(OP_MULT, 32'hFFFFFFFF, 32'd2);
        wait_idle();

        expect_op(32'h00000001, 32'hFFFFFFFE, 5);
        do_op(OP_MULTU, 32'hFFFFFFFF, 32'd2);
        wait_idle();

        expect_op(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        do_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle();

        expect_op(32'h00000000, 32'h80000000, 10);
        do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();

        expect_op(32'd2, 32'd14, 10);
        do_op(OP_DIVU, 32'd100, 32'd7);
        wait_idle();

        expect_op(32'hFFFFFFFF, 32'hFFFFFFF4, 5);
        do_op(OP_MULT, 32'd3, 32'hFFFFFFFC);
        wait_idle();

        // Starts while busy must be dropped; the first op still commits.
        expect_op(32'd0, 32'h2A, 5);
        do_op(OP_MULT, 32'd6, 32'd7);
        do_op(OP_MTLO, 32'h5, 32'h0);
        do_op(OP_MULTU, 32'd9, 32'd9);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("ignored_LO", LO, 32'h2A);

        expect_op(32'd1, 32'hFFFFFFFD, 10);
        do_op(OP_DIV, 32'd7, 32'hFFFFFFFE);
        wait_idle();

`ifdef MD_FLUSH_EN
        save_hi = HI; save_lo = LO;
        do_op(OP_MULT, 32'd5, 32'd5);
        @(negedge clk);
        flush = 1'b1;
        abort_flag = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        repeat (8) @(negedge clk);
        chk("flush_HI", HI, save_hi);
        chk("flush_LO", LO, save_lo);
        expect_op(32'd0, 32'd6, 5);
        do_op(OP_MULT, 32'd2, 32'd3);
        wait_idle();
`endif

        // Reset during cycle 3 of a div discards it and clears HI/LO immediately.
        do_op(OP_DIV, 32'd100, 32'd3);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_HI", HI, 32'd0);
        chk("rst_mid_LO", LO, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("rst_after_busy", {31'd0, busy}, 32'd0);
        chk("rst_after_HI", HI, 32'd0);
        chk("rst_after_LO", LO, 32'd0);

        save_hi = 32'd0;
        save_lo = save_hi;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
